// File: rtl/if_id_queue.sv
// IF/ID pipeline buffer: DEPTH-entry FIFO of {pc, inst} with valid/ready on both sides.
// Flush empties the queue; an empty queue presents an all-zero bubble to the decoder.
module if_id_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter bit BYTE_SWAP  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         if_valid_i,
    input  logic [ADDR_WIDTH-1:0]        if_pc,
    input  logic [INST_WIDTH-1:0]        if_inst,
    output logic                         if_ready_o,
    input  logic                         IFID_discard_i,
    input  logic                         id_ready_i,
    output logic                         id_valid_o,
    output logic [ADDR_WIDTH-1:0]        id_pc,
    output logic [INST_WIDTH-1:0]        id_inst,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NB = INST_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_enq;
    logic                  w_deq;
    logic [INST_WIDTH-1:0] w_inst_in;
    logic [DEPTH-1:0]      w_we;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Discard suppresses both sides of the handshake in the cycle it is raised.
    assign w_enq = if_valid_i && !w_full && !IFID_discard_i;
    assign w_deq = id_ready_i && !w_empty && !IFID_discard_i;

    genvar gi;
    generate
        if (BYTE_SWAP) begin : g_swap
            for (gi = 0; gi < NB; gi++) begin : g_byte
                assign w_inst_in[8*gi +: 8] = if_inst[8*(NB-1-gi) +: 8];
            end
        end else begin : g_noswap
            assign w_inst_in = if_inst;
        end

        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign w_we[gi] = w_enq && (r_wptr == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_inst_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_pc_mem[i]   <= if_pc;
                    r_inst_mem[i] <= w_inst_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (IFID_discard_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign if_ready_o = !w_full;
    assign id_valid_o = !w_empty;
    assign id_pc      = w_empty ? '0 : r_pc_mem[r_rptr];
    assign id_inst    = w_empty ? '0 : r_inst_mem[r_rptr];
    assign count_o    = r_count;

endmodule
